mode_param_latch: RTL and testbench

- Parametrised, registered successor to the 12-entry difficulty/memory parameter mux.
- Holds a table of N_LEVELS x N_MEMS game-parameter entries (each BITS wide).
- Accepts a level/memory-mode selection through a load handshake and locks it for the duration of a round.
- Drives the selected entry on a registered output with a valid flag and flags invalid selections.
- Sits between the mode-selection switches and the PlaySeq datapath (timeout, sequence-length and memory-size consumers).

---
 rtl/mode_param_latch_pkg.sv | 25 ++
 rtl/mode_param_latch_mux_n_param.sv | 20 ++
 rtl/mode_param_latch.sv | 93 +++++++++
 tb/tb_mode_param_latch.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mode_param_latch_pkg.sv
// mode_param_latch_pkg: shared FSM states, level/memory encodings and default fill.
package mode_param_latch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LATCH  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        LVL_FACIL   = 2'd0,
        LVL_MEDIO   = 2'd1,
        LVL_DIFICIL = 2'd2
    } level_t;

    typedef enum logic [1:0] {
        MEM_FACIL         = 2'd0,
        MEM_MEDIA         = 2'd1,
        MEM_DIFICIL       = 2'd2,
        MEM_PERSONALIZADA = 2'd3
    } mem_t;

    localparam logic DEFAULT_FILL_BIT = 1'b1;

endpackage

// File: rtl/mode_param_latch_mux_n_param.sv
// mux_n_param: combinational N-to-1 indexed mux; out-of-range index yields all ones.
module mux_n_param
    import mode_param_latch_pkg::*;
#(
    parameter int BITS = 4,
    parameter int N    = 12,
    localparam int IW  = $clog2(N) + 1
) (
    input  logic [N*BITS-1:0] i_data,
    input  logic [IW-1:0]     i_idx,
    output logic [BITS-1:0]   o_data
);

    always_comb begin
        o_data = {BITS{DEFAULT_FILL_BIT}};
        for (int k = 0; k < N; k++)
            if (i_idx == IW'(k)) o_data = i_data[k*BITS +: BITS];
    end

endmodule

// File: rtl/mode_param_latch.sv
// mode_param_latch: handshake-latched level/memory selection driving a registered table entry.
module mode_param_latch
    import mode_param_latch_pkg::*;
#(
    parameter int BITS     = 4,
    parameter int N_LEVELS = 3,
    parameter int N_MEMS   = 4,
    localparam int LW      = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1,
    localparam int MW      = (N_MEMS > 1) ? $clog2(N_MEMS) : 1,
    localparam int N       = N_LEVELS * N_MEMS,
    localparam int IW      = $clog2(N) + 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [N*BITS-1:0] i_table_in,
    input  logic [LW-1:0]     i_level_sel,
    input  logic [MW-1:0]     i_mem_sel,
    input  logic              i_load,
    input  logic              i_release,
    output logic              o_ready,
    output logic [BITS-1:0]   o_param_out,
    output logic              o_param_valid,
    output logic              o_sel_error
);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [BITS-1:0] r_param;
    logic            r_valid;
    logic            r_error;
    logic            r_ready;
    logic [IW-1:0]   w_idx;
    logic            w_sel_ok;
    logic [BITS-1:0] w_entry;

    // Extra MSB on the comparisons keeps counts that equal 2**width from wrapping to 0.
    assign w_sel_ok = ({1'b0, i_level_sel} < (LW+1)'(N_LEVELS)) && ({1'b0, i_mem_sel} < (MW+1)'(N_MEMS));
    assign w_idx    = IW'(i_level_sel) * IW'(N_MEMS) + IW'(i_mem_sel);

    mux_n_param #(.BITS(BITS), .N(N)) u_mux (
        .i_data (i_table_in),
        .i_idx  (r_idx),
        .o_data (w_entry)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_param <= {BITS{DEFAULT_FILL_BIT}};
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (i_load) begin
                    if (w_sel_ok) begin
                        r_idx   <= w_idx;
                        r_error <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= LATCH;
                    end else begin
                        r_error <= 1'b1;
                        r_param <= {BITS{DEFAULT_FILL_BIT}};
                    end
                end
                LATCH: begin
                    r_param <= w_entry;
                    r_valid <= 1'b1;
                    r_state <= LOCKED;
                end
                LOCKED: if (i_release) begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_param <= w_entry;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready       = r_ready;
    assign o_param_out   = r_param;
    assign o_param_valid = r_valid;
    assign o_sel_error   = r_error;

endmodule

// File: tb/tb_mode_param_latch.sv
// tb_mode_param_latch: directed checks of reset, latching, lock, table tracking, errors and aborts.
module tb_mode_param_latch;
    import mode_param_latch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] tbl;
    logic [1:0]  lvl;
    logic [1:0]  mem;
    logic        load;
    logic        rel;
    logic        ready;
    logic [3:0]  param;
    logic        valid;
    logic        err;
    int          n_total = 0;
    int          n_pass  = 0;

    mode_param_latch #(.BITS(4), .N_LEVELS(3), .N_MEMS(4)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_table_in    (tbl),
        .i_level_sel   (lvl),
        .i_mem_sel     (mem),
        .i_load        (load),
        .i_release     (rel),
        .o_ready       (ready),
        .o_param_out   (param),
        .o_param_valid (valid),
        .o_sel_error   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        rel  = 1'b0;
        lvl  = '0;
        mem  = '0;
        for (int k = 0; k < 12; k++) tbl[k*4 +: 4] = 4'(k + 1);
        tick();
        tick();
        chk("rst_param", 32'(param), 32'hF);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_err",   32'(err),   0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(ready), 1);
        lvl  = LVL_DIFICIL;
        mem  = MEM_MEDIA;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("latch_ready", 32'(ready), 0);
        chk("latch_valid", 32'(valid), 0);
        tick();
        chk("nom_param", 32'(param), 32'hA);
        chk("nom_valid", 32'(valid), 1);
        chk("nom_ready", 32'(ready), 0);
        lvl  = LVL_FACIL;
        mem  = MEM_FACIL;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("lock_ign1", 32'(param), 32'hA);
        tick();
        chk("lock_ign2", 32'(param), 32'hA);
        tbl[9*4 +: 4] = 4'h3;
        chk("edit_pre", 32'(param), 32'hA);
        tick();
        chk("edit_post", 32'(param), 32'h3);
        chk("edit_valid", 32'(valid), 1);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("rel_ready", 32'(ready), 1);
        chk("rel_valid", 32'(valid), 0);
        chk("rel_param", 32'(param), 32'h3);
        lvl  = 2'd3;
        mem  = MEM_FACIL;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("inv_err",   32'(err),   1);
        chk("inv_param", 32'(param), 32'hF);
        chk("inv_ready", 32'(ready), 1);
        chk("inv_valid", 32'(valid), 0);
        tick();
        chk("inv_stay", 32'(ready), 1);
        lvl  = LVL_FACIL;
        mem  = MEM_PERSONALIZADA;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("clr_err",   32'(err),   0);
        chk("clr_ready", 32'(ready), 0);
        tick();
        chk("pers_param", 32'(param), 32'h4);
        chk("pers_valid", 32'(valid), 1);
        lvl  = LVL_MEDIO;
        mem  = MEM_FACIL;
        load = 1'b1;
        rel  = 1'b1;
        tick();
        load = 1'b0;
        rel  = 1'b0;
        chk("lr_ready", 32'(ready), 1);
        chk("lr_valid", 32'(valid), 0);
        chk("lr_param", 32'(param), 32'h4);
        tick();
        chk("lr_norelatch", 32'(ready), 1);
        chk("lr_param2",    32'(param), 32'h4);
        mem  = MEM_DIFICIL;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("abort_latch", 32'(ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_param", 32'(param), 32'hF);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_ready", 32'(ready), 1);
        tick();
        chk("abort_idle", 32'(valid), 0);
        chk("abort_hold", 32'(param), 32'hF);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
